// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch defaults and fetch-sequencer state encoding.
package cpu_pkg;

  localparam int unsigned FETCH_PC_W     = 10;
  localparam int unsigned FETCH_DATA_W   = 32;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_KILL  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs one req/ack transaction to instruction memory at a
// time, and hands {pc_out, inst} to decode while absorbing wait states, stalls and redirects.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned          PC_W     = FETCH_PC_W,
  parameter int unsigned          DATA_W   = FETCH_DATA_W,
  parameter logic [PC_W-1:0]      RESET_PC = PC_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   pc_out
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [PC_W-1:0]   pc_inc_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      inst_q     <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  // Next-state, next-PC mux and capture logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q & stall;
    pc_inc_c = pc_q + PC_W'(1);

    unique case (state_q)
      FS_IDLE: begin
        state_d = FS_FETCH;
        if (branch) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end
      end
      FS_FETCH: begin
        if (branch) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          state_d = imem_ack ? FS_FETCH : FS_KILL;
        end else if (valid_q && stall) begin
          // Single capture stage is occupied: drop the request and park
          state_d = FS_HOLD;
        end else if (imem_ack) begin
          inst_d   = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_inc_c;
        end
      end
      FS_HOLD: begin
        if (branch) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          state_d = FS_FETCH;
        end else if (!stall) begin
          state_d = FS_FETCH;
        end
      end
      FS_KILL: begin
        valid_d = 1'b0;
        if (branch) begin
          pc_d = branch_target;
        end
        if (imem_ack) begin
          state_d = FS_FETCH;
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase

    // The squashed request keeps its old address until memory answers it
    req_addr_d = (state_d == FS_KILL) ? req_addr_q : pc_d;
    req_d      = (state_d == FS_FETCH) || (state_d == FS_KILL);
  end

  assign imem_req   = req_q;
  assign imem_addr  = req_addr_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign pc_out     = pc_out_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a flag-based
// behavioural model of the fetch sequencer.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch = 1'b0;
  logic [9:0]  branch_target = '0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [9:0]  pc_out;

  int total = 0;
  int bad   = 0;

  // Model: request in flight, request squashed, decode buffer full
  logic [9:0]  m_pc = '0;
  logic [9:0]  m_addr = '0;
  logic [9:0]  m_pcout = '0;
  logic [31:0] m_inst = '0;
  logic        m_req = 1'b0;
  logic        m_disc = 1'b0;
  logic        m_valid = 1'b0;
  int          wcnt = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_W(10), .DATA_W(32), .RESET_PC(10'd0)) dut (
    .clk(clk), .rst(rst), .branch(branch), .branch_target(branch_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc_out(pc_out)
  );

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return 32'hC0DE_0000 ^ ({22'd0, a} * 32'd40503);
  endfunction

  function automatic logic [53:0] dut_o();
    return {imem_req, imem_addr, inst_valid, pc_out, inst};
  endfunction

  function automatic logic [53:0] mod_o();
    return {m_req, m_addr, m_valid, m_pcout, m_inst};
  endfunction

  task automatic model_step();
    logic cons;
    cons = m_valid && !stall;
    if (rst) begin
      m_pc = '0; m_addr = '0; m_req = 1'b0; m_disc = 1'b0;
      m_valid = 1'b0; m_inst = '0; m_pcout = '0;
    end else if (!m_req) begin
      if (branch) begin
        m_pc = branch_target; m_valid = 1'b0; m_req = 1'b1;
      end else if (!m_valid) begin
        m_req = 1'b1;
      end else if (cons) begin
        m_valid = 1'b0; m_req = 1'b1;
      end
      m_addr = m_pc;
    end else if (m_disc) begin
      if (branch) m_pc = branch_target;
      if (imem_ack) begin
        m_disc = 1'b0; m_addr = m_pc;
      end
    end else begin
      if (branch) begin
        m_pc = branch_target; m_valid = 1'b0;
        if (imem_ack) m_addr = m_pc;
        else m_disc = 1'b1;
      end else if (m_valid && stall) begin
        m_req = 1'b0;
      end else if (imem_ack) begin
        m_inst = imem_rdata; m_pcout = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 10'd1; m_addr = m_pc;
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Drive one cycle's inputs, then wait to the sampling point
  task automatic apply(input logic r, input logic b, input logic [9:0] t,
                       input logic s, input logic a);
    rst = r; branch = b; branch_target = t; stall = s; imem_ack = a;
    imem_rdata = mem_word(m_addr);
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst && m_req && !imem_ack) wcnt++;
    else wcnt = 0;
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    apply(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    adv();
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 10'h155, 1'b1, 1'b1);
    adv();
    apply(1'b1, 1'b1, 10'h2AA, 1'b0, 1'b1);
    total++;
    if (dut_o() !== {1'b0, 10'd0, 1'b0, 10'd0, 32'd0}) begin
      bad++; $display("FAIL reset_values: got=%h exp=%h", dut_o(), {1'b0, 10'd0, 1'b0, 10'd0, 32'd0});
    end
    total++;
    if (dut_o() !== mod_o()) begin
      bad++; $display("FAIL reset_model: got=%h exp=%h", dut_o(), mod_o());
    end
    adv();
  endtask

  task automatic test_zero_wait();
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, 10'd0, 1'b0, m_req);
      total++;
      if (dut_o() !== mod_o()) begin
        bad++; $display("FAIL zw_model k=%0d: got=%h exp=%h", k, dut_o(), mod_o());
      end
      if (k >= 2) begin
        total++;
        if (inst_valid !== 1'b1 || pc_out !== 10'(k - 2)) begin
          bad++; $display("FAIL zw_seq k=%0d: got v=%b pc=%h exp v=1 pc=%h", k, inst_valid, pc_out, 10'(k - 2));
        end
      end
      adv();
    end
  endtask

  task automatic test_wait_states();
    int held5, dbl;
    logic prev_v;
    held5 = 0; dbl = 0; prev_v = 1'b0;
    reset_dut();
    for (int k = 0; k < 30; k++) begin
      apply(1'b0, 1'b0, 10'd0, 1'b0, m_req && (wcnt >= 2));
      total++;
      if (dut_o() !== mod_o()) begin
        bad++; $display("FAIL ws_model k=%0d: got=%h exp=%h", k, dut_o(), mod_o());
      end
      if (imem_req === 1'b1 && imem_addr === 10'd5) held5++;
      if (prev_v && inst_valid === 1'b1) dbl++;
      prev_v = (inst_valid === 1'b1);
      adv();
    end
    total++;
    if (held5 !== 3) begin
      bad++; $display("FAIL ws_addr5_cycles: got=%0d exp=3", held5);
    end
    total++;
    if (dbl !== 0) begin
      bad++; $display("FAIL ws_pulse_width: got=%0d back-to-back valids exp=0", dbl);
    end
  endtask

  task automatic test_stall();
    logic got;
    reset_dut();
    for (int n = 0; n < 20 && !(m_valid && m_pcout == 10'd7); n++) begin
      apply(1'b0, 1'b0, 10'd0, 1'b0, m_req);
      adv();
    end
    total++;
    if (!(m_valid && m_pcout == 10'd7)) begin
      bad++; $display("FAIL stall_reach7: got pc_out=%h exp=007", m_pcout);
    end
    for (int s = 0; s < 4; s++) begin
      apply(1'b0, 1'b0, 10'd0, 1'b1, 1'b1);
      total++;
      if (inst_valid !== 1'b1 || pc_out !== 10'd7 || inst !== mem_word(10'd7)) begin
        bad++; $display("FAIL stall_frozen s=%0d: got v=%b pc=%h i=%h exp v=1 pc=007 i=%h", s, inst_valid, pc_out, inst, mem_word(10'd7));
      end
      if (s > 0) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++; $display("FAIL stall_req s=%0d: got=%b exp=0", s, imem_req);
        end
      end
      adv();
    end
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
      total++;
      if (dut_o() !== mod_o()) begin
        bad++; $display("FAIL stall_model n=%0d: got=%h exp=%h", n, dut_o(), mod_o());
      end
      if (inst_valid === 1'b1 && pc_out !== 10'd7) begin
        got = 1'b1;
        total++;
        if (pc_out !== 10'd8) begin
          bad++; $display("FAIL stall_next: got pc=%h exp=008", pc_out);
        end
      end
      adv();
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL stall_timeout: got no new inst exp pc=008");
    end
  endtask

  task automatic test_kill();
    reset_dut();
    apply(1'b0, 1'b1, 10'h012, 1'b0, 1'b0);
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h012) begin
      bad++; $display("FAIL kill_req12: got r=%b a=%h exp r=1 a=012", imem_req, imem_addr);
    end
    adv();
    apply(1'b0, 1'b1, 10'h100, 1'b0, 1'b0);
    adv();
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 10'd0, 1'b0, k == 1);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 10'h012 || inst_valid !== 1'b0) begin
        bad++; $display("FAIL kill_hold k=%0d: got r=%b a=%h v=%b exp r=1 a=012 v=0", k, imem_req, imem_addr, inst_valid);
      end
      adv();
    end
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h100 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL kill_redirect: got r=%b a=%h v=%b exp r=1 a=100 v=0", imem_req, imem_addr, inst_valid);
    end
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    total++;
    if (inst_valid !== 1'b1 || pc_out !== 10'h100 || inst !== mem_word(10'h100)) begin
      bad++; $display("FAIL kill_first: got v=%b pc=%h i=%h exp v=1 pc=100 i=%h", inst_valid, pc_out, inst, mem_word(10'h100));
    end
    adv();
  endtask

  task automatic test_branch_ack_stall();
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 10'd0, 1'b0, m_req);
      adv();
    end
    apply(1'b0, 1'b1, 10'h2A0, 1'b1, 1'b1);
    total++;
    if (inst_valid !== 1'b1 || pc_out !== 10'd2) begin
      bad++; $display("FAIL bas_pre: got v=%b pc=%h exp v=1 pc=002", inst_valid, pc_out);
    end
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h2A0) begin
      bad++; $display("FAIL bas_drop: got v=%b r=%b a=%h exp v=0 r=1 a=2a0", inst_valid, imem_req, imem_addr);
    end
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b1, 1'b1);
    total++;
    if (inst_valid !== 1'b1 || pc_out !== 10'h2A0) begin
      bad++; $display("FAIL bas_target: got v=%b pc=%h exp v=1 pc=2a0", inst_valid, pc_out);
    end
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b1, 1'b1);
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1 || pc_out !== 10'h2A0) begin
      bad++; $display("FAIL bas_hold: got r=%b v=%b pc=%h exp r=0 v=1 pc=2a0", imem_req, inst_valid, pc_out);
    end
    adv();
    apply(1'b0, 1'b1, 10'h0C5, 1'b1, 1'b1);
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h0C5) begin
      bad++; $display("FAIL bas_hold_drop: got v=%b r=%b a=%h exp v=0 r=1 a=0c5", inst_valid, imem_req, imem_addr);
    end
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    total++;
    if (inst_valid !== 1'b1 || pc_out !== 10'h0C5) begin
      bad++; $display("FAIL bas_hold_target: got v=%b pc=%h exp v=1 pc=0c5", inst_valid, pc_out);
    end
    adv();
  endtask

  task automatic test_wrap_reset();
    reset_dut();
    apply(1'b0, 1'b1, 10'h3FE, 1'b0, 1'b0);
    adv();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 10'd0, 1'b0, m_req);
      if (k == 2) begin
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000 || pc_out !== 10'h3FF) begin
          bad++; $display("FAIL wrap_addr: got r=%b a=%h pc=%h exp r=1 a=000 pc=3ff", imem_req, imem_addr, pc_out);
        end
      end
      if (k == 3) begin
        total++;
        if (inst_valid !== 1'b1 || pc_out !== 10'h000) begin
          bad++; $display("FAIL wrap_inst: got v=%b pc=%h exp v=1 pc=000", inst_valid, pc_out);
        end
      end
      adv();
    end
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    adv();
    apply(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 10'h000) begin
      bad++; $display("FAIL rst_mid: got r=%b v=%b a=%h exp r=0 v=0 a=000", imem_req, inst_valid, imem_addr);
    end
    adv();
    apply(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    total++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 10'h000) begin
      bad++; $display("FAIL rst_late_ack: got r=%b v=%b a=%h exp r=1 v=0 a=000", imem_req, inst_valid, imem_addr);
    end
    adv();
  endtask

  task automatic test_random();
    logic r, b, s, a;
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(99) == 0);
      b = ($urandom_range(9) == 0);
      s = ($urandom_range(2) == 0);
      a = $urandom_range(1) == 1;
      apply(r, b, 10'($urandom), s, a);
      total++;
      if (dut_o() !== mod_o()) begin
        bad++; $display("FAIL rand_model n=%0d: got=%h exp=%h", n, dut_o(), mod_o());
      end
      adv();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish exp finish before timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_kill();
    test_branch_ack_stall();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
